// File: rtl/ca_generation_sequencer_if.sv
// Host/observer bundle for the CA generation sequencer.
// Host drives the job description; the sequencer returns progress and rows.
interface ca_generation_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
);
  logic             start;
  logic [7:0]       rule;
  logic [WIDTH-1:0] init_row;
  logic [GEN_W-1:0] gen_count;
  logic             boundary;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] row;
  logic             row_valid;
  logic [GEN_W-1:0] gen_index;

  modport master (
    output start, rule, init_row, gen_count, boundary,
    input  busy, done, row, row_valid, gen_index
  );

  modport slave (
    input  start, rule, init_row, gen_count, boundary,
    output busy, done, row, row_valid, gen_index
  );
endinterface

// File: rtl/ca_generation_sequencer.sv
// Evolves an elementary CA row one cell per cycle with a single shared
// rule evaluator; the next row is built aside and committed per generation.
module ca_generation_sequencer #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input logic clk,
  input logic rst,
  ca_generation_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    FIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             scan;
  logic             commit;

  logic [7:0]       rule_q;
  logic             bnd_q;
  logic [GEN_W-1:0] gen_count_q;
  logic [GEN_W-1:0] gen_q;
  logic [GEN_W-1:0] gen_inc;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] nxt_q;
  logic [WIDTH-1:0] row_q;
  logic             row_valid_q;

  logic             lb;
  logic             rb;
  logic [WIDTH+1:0] ext;
  logic [2:0]       nh;
  logic             next_cell;
  logic             last_gen;

  assign gen_inc  = gen_q + GEN_W'(1);
  assign last_gen = (gen_inc == gen_count_q);

  // Shared evaluator: pad the row with its edge neighbours so every
  // cell's {L,C,R} is a plain 3-bit window starting at its index.
  always_comb begin
    lb        = bnd_q ? 1'b0 : cur_q[0];
    rb        = bnd_q ? 1'b0 : cur_q[WIDTH-1];
    ext       = {lb, cur_q, rb};
    nh        = ext[idx_q +: 3];
    next_cell = rule_q[nh];
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    scan    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.gen_count == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        scan = 1'b1;
        if (idx_q == LAST) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = last_gen ? FIN : SCAN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Job latch, scan buffer, committed row and progress counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rule_q      <= '0;
      bnd_q       <= 1'b0;
      gen_count_q <= '0;
      gen_q       <= '0;
      idx_q       <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      row_q       <= '0;
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= commit;
      if (load) begin
        rule_q      <= bus.rule;
        bnd_q       <= bus.boundary;
        gen_count_q <= bus.gen_count;
        cur_q       <= bus.init_row;
        row_q       <= bus.init_row;
        gen_q       <= '0;
        idx_q       <= '0;
      end
      if (scan) begin
        nxt_q[idx_q] <= next_cell;
        idx_q        <= idx_q + IDX_W'(1);
      end
      if (commit) begin
        cur_q <= nxt_q;
        row_q <= nxt_q;
        gen_q <= gen_inc;
        idx_q <= '0;
      end
    end
  end

  assign bus.busy      = (state_q == SCAN) || (state_q == COMMIT);
  assign bus.done      = (state_q == FIN);
  assign bus.row       = row_q;
  assign bus.row_valid = row_valid_q;
  assign bus.gen_index = gen_q;
endmodule

// File: tb/tb_ca_generation_sequencer.sv
// Bench for ca_generation_sequencer: directed vectors plus random runs
// checked against a row-level CA model.
module tb_ca_generation_sequencer;
  localparam int W = 8;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] fin_row;
  logic [W-1:0] seen[$];

  ca_generation_sequencer_if #(.WIDTH(W), .GEN_W(G)) bus ();

  ca_generation_sequencer #(.WIDTH(W), .GEN_W(G)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] r,
                                              input logic [7:0] rl,
                                              input logic bnd);
    logic [W-1:0] o;
    int l, c, rr;
    for (int i = 0; i < W; i++) begin
      l  = (i == W-1 && bnd) ? 0 : int'(r[(i+1) % W]);
      c  = int'(r[i]);
      rr = (i == 0 && bnd) ? 0 : int'(r[(i+W-1) % W]);
      o[i] = rl[l*4 + c*2 + rr];
    end
    return o;
  endfunction

  task automatic scramble();
    bus.rule      = 8'($urandom);
    bus.init_row  = W'($urandom);
    bus.gen_count = G'($urandom);
    bus.boundary  = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string nm, input logic [7:0] rl,
                     input logic [W-1:0] init, input int g,
                     input logic bnd, input bit disturb);
    logic [W-1:0] m;
    logic [W-1:0] exp_rows[$];
    int exp_done, cyc, nv;
    bit got_done;
    m = init;
    for (int k = 0; k < g; k++) begin
      m = model_next(m, rl, bnd);
      exp_rows.push_back(m);
    end
    seen.delete();
    bus.rule      = rl;
    bus.init_row  = init;
    bus.gen_count = G'(g);
    bus.boundary  = bnd;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    scramble();
    exp_done = 1 + g * (W + 1);
    cyc = 1;
    nv = 0;
    got_done = 0;
    check({nm, "/seed"}, 32'(bus.row), 32'(init));
    while (!got_done && cyc <= exp_done + 4) begin
      check({nm, "/busy"}, 32'(bus.busy), 32'(cyc < exp_done));
      if (bus.row_valid) begin
        if (nv < g) begin
          check({nm, "/row"}, 32'(bus.row), 32'(exp_rows[nv]));
          check({nm, "/rv_cyc"}, cyc, 1 + (nv + 1) * (W + 1));
          check({nm, "/gidx"}, 32'(bus.gen_index), nv + 1);
        end
        seen.push_back(bus.row);
        nv++;
      end
      if (bus.done) begin
        got_done = 1;
        check({nm, "/done_cyc"}, cyc, exp_done);
        check({nm, "/gen_fin"}, 32'(bus.gen_index), g);
        check({nm, "/n_rv"}, nv, g);
        check({nm, "/row_fin"}, 32'(bus.row), 32'(m));
      end else begin
        if (disturb && cyc == 3) begin
          scramble();
          bus.start = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        cyc++;
      end
    end
    if (!got_done) check({nm, "/timeout"}, 0, 1);
    fin_row = bus.row;
    if (disturb) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({nm, "/idle_busy"}, 32'(bus.busy), 0);
    check({nm, "/idle_done"}, 32'(bus.done), 0);
    check({nm, "/idle_gidx"}, 32'(bus.gen_index), g);
    tick();
    check({nm, "/idle_busy2"}, 32'(bus.busy), 0);
    check({nm, "/idle_row"}, 32'(bus.row), 32'(m));
  endtask

  task automatic abort_run();
    bus.rule      = 8'h5A;
    bus.init_row  = 8'b0001_0000;
    bus.gen_count = G'(4);
    bus.boundary  = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 1 + (W + 1) + 3; c++) tick();
    check("abort/in_scan", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort/busy", 32'(bus.busy), 0);
    check("abort/done", 32'(bus.done), 0);
    check("abort/row", 32'(bus.row), 0);
    check("abort/gidx", 32'(bus.gen_index), 0);
    check("abort/rv", 32'(bus.row_valid), 0);
    for (int c = 0; c < 3 * (W + 1); c++) begin
      tick();
      check("abort/quiet", 32'({bus.done, bus.row_valid, bus.busy}), 0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.rule      = '0;
    bus.init_row  = '0;
    bus.gen_count = '0;
    bus.boundary  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst/busy", 32'(bus.busy), 0);
    check("rst/done", 32'(bus.done), 0);
    check("rst/rv", 32'(bus.row_valid), 0);
    check("rst/row", 32'(bus.row), 0);
    check("rst/gidx", 32'(bus.gen_index), 0);
    rst = 1'b0;
    tick();

    run("r90", 8'h5A, 8'b0001_0000, 1, 1'b0, 1'b0);
    check("r90/vec", 32'(fin_row), 32'(8'b0010_1000));
    run("wrap", 8'h5A, 8'b0000_0001, 1, 1'b0, 1'b0);
    check("wrap/vec", 32'(fin_row), 32'(8'b1000_0010));
    run("fixed", 8'h5A, 8'b0000_0001, 1, 1'b1, 1'b0);
    check("fixed/vec", 32'(fin_row), 32'(8'b0000_0010));
    run("r110", 8'h6E, 8'b0000_0001, 3, 1'b0, 1'b0);
    check("r110/n", seen.size(), 3);
    if (seen.size() == 3) begin
      check("r110/v0", 32'(seen[0]), 32'(8'b0000_0011));
      check("r110/v1", 32'(seen[1]), 32'(8'b0000_0111));
      check("r110/v2", 32'(seen[2]), 32'(8'b0000_1101));
    end
    run("g0", 8'h5A, 8'hA5, 0, 1'b0, 1'b0);
    check("g0/vec", 32'(fin_row), 32'(8'hA5));
    run("dist", 8'h6E, 8'b0000_0001, 3, 1'b0, 1'b1);
    check("dist/vec", 32'(fin_row), 32'(8'b0000_1101));

    abort_run();
    run("fresh", 8'h5A, 8'b0001_0000, 2, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run("rnd", 8'($urandom), W'($urandom), int'($urandom_range(0, 6)),
          1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
